fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch buffer between instruction memory and decode. It owns
// the fetch PC, issues in-order word requests to memory, buffers the returned
// instructions with their PC in a DEPTH-entry FIFO, and presents the head to
// decode. A redirect flushes the FIFO, drops responses that are still in
// flight and restarts fetch at the new target.
//
// Ports:
//   clk              in   sole clock, rising edge
//   reset            in   asynchronous reset, active low
//   i_redirect       in   taken branch/jump from execute
//   i_redirect_pc    in   redirect target (low two bits ignored)
//   o_imem_req_valid out  request pending
//   i_imem_req_ready in   memory accepts request
//   o_imem_req_addr  out  word address of request
//   i_imem_rsp_valid in   in-order response, never back-pressured
//   i_imem_rsp_data  in   returned instruction
//   o_fetch_valid    out  FIFO head valid
//   i_decode_ready   in   decode consumes head
//   o_fetch_inst     out  head instruction (NOP when empty)
//   o_fetch_pc       out  head PC (0 when empty)
//   o_fetch_pc_inc   out  head PC + 4 (4 when empty)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_fetch_valid,
    input  logic        i_decode_ready,
    output logic [31:0] o_fetch_inst,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc_inc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   inst_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;

    logic [SW-1:0] used_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          keep_s;
    logic          drop_s;
    logic          pop_s;
    logic [31:0]   rsp_pc_s;

    // Credit check and per-cycle event decode from registered state only.
    always_comb begin
        used_s      = SW'(count_r) + SW'(outstanding_r) + SW'(discard_r);
        // Gated by reset so the request line drops the moment reset asserts.
        req_valid_s = reset && !i_redirect && (used_s < DEPTH_S);
        accept_s    = req_valid_s && i_imem_req_ready;
        keep_s      = i_imem_rsp_valid && (discard_r == CW'(0));
        drop_s      = i_imem_rsp_valid && (discard_r != CW'(0));
        pop_s       = (count_r != CW'(0)) && i_decode_ready && !i_redirect;
        // Oldest kept request was issued 'outstanding' words before fetch_pc.
        rsp_pc_s    = fetch_pc_r - 32'({outstanding_r, 2'b00});
    end

    // Fetch PC, FIFO pointers and request bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            wr_ptr_r      <= AW'(0);
            rd_ptr_r      <= AW'(0);
            count_r       <= CW'(0);
            outstanding_r <= CW'(0);
            discard_r     <= CW'(0);
        end else if (i_redirect) begin
            // Masking keeps the target word aligned.
            fetch_pc_r    <= i_redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_r      <= AW'(0);
            rd_ptr_r      <= AW'(0);
            count_r       <= CW'(0);
            outstanding_r <= CW'(0);
            // Everything still expected becomes garbage; a response landing
            // now is one of those and is consumed immediately.
            discard_r     <= discard_r + outstanding_r - CW'(i_imem_rsp_valid);
        end else begin
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (keep_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r       <= count_r + CW'(keep_s) - CW'(pop_s);
            outstanding_r <= outstanding_r + CW'(accept_s) - CW'(keep_s);
            discard_r     <= discard_r - CW'(drop_s);
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (keep_s && !i_redirect) begin
            inst_mem_r[wr_ptr_r] <= i_imem_rsp_data;
            pc_mem_r[wr_ptr_r]   <= rsp_pc_s;
        end
    end

    // Head presentation with the defined empty values.
    always_comb begin
        o_fetch_valid  = 1'b0;
        o_fetch_inst   = NOP;
        o_fetch_pc     = 32'h0000_0000;
        o_fetch_pc_inc = 32'h0000_0004;
        if (count_r != CW'(0)) begin
            o_fetch_valid  = 1'b1;
            o_fetch_inst   = inst_mem_r[rd_ptr_r];
            o_fetch_pc     = pc_mem_r[rd_ptr_r];
            o_fetch_pc_inc = pc_mem_r[rd_ptr_r] + 32'd4;
        end else begin
            o_fetch_valid  = 1'b0;
        end
    end

    assign o_imem_req_valid = req_valid_s;
    assign o_imem_req_addr  = fetch_pc_r;

    fetch_queue_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .rsp_valid   (i_imem_rsp_valid),
        .fifo_write  (keep_s && !i_redirect),
        .count       (count_r),
        .outstanding (outstanding_r),
        .discard     (discard_r)
    );
endmodule

// ---------------------------------------------------------------------------
// fetch_queue_checker
// Simulation-only protocol checks for fetch_queue: no unexpected response,
// no FIFO write while full.
// Ports: clk, reset, rsp_valid, fifo_write, count, outstanding, discard.
// ---------------------------------------------------------------------------
module fetch_queue_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          rsp_valid,
    input logic          fifo_write,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] discard
);
    a_rsp_expected : assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> ((outstanding != CW'(0)) || (discard != CW'(0))));

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        fifo_write |-> (count != CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Randomized bench for fetch_queue with a queue-based reference model of the
// fetch/buffer/redirect behaviour and an in-order memory model returning
// addr ^ 0xA5 after a configurable latency.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_fetch_valid;
    logic        i_decode_ready;
    logic [31:0] o_fetch_inst;
    logic [31:0] o_fetch_pc;
    logic [31:0] o_fetch_pc_inc;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_fetch_valid    (o_fetch_valid),
        .i_decode_ready   (i_decode_ready),
        .o_fetch_inst     (o_fetch_inst),
        .o_fetch_pc       (o_fetch_pc),
        .o_fetch_pc_inc   (o_fetch_pc_inc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    // Reference model state
    mreq_t       mem_q[$];     // every accepted request, kept or not
    logic [31:0] kept_q[$];    // PCs of in-flight requests that will be buffered
    logic [31:0] fifo_q[$];    // PCs buffered for decode
    int          discard_cnt;
    logic [31:0] model_pc;
    int          edge_no;

    // Stimulus knobs
    int          ready_pct;
    int          dready_pct;
    int          redir_pct;
    int          lat_min;
    int          lat_max;
    logic        force_redir;
    logic [31:0] force_pc;

    int n_checks;
    int n_pass;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        kept_q.delete();
        fifo_q.delete();
        discard_cnt = 0;
        model_pc    = RESET_PC;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"},   32'(o_imem_req_valid), 32'd0);
        check_val({tag, "_fetch_valid"}, 32'(o_fetch_valid),    32'd0);
        check_val({tag, "_inst"},        o_fetch_inst,          NOP);
        check_val({tag, "_pc"},          o_fetch_pc,            32'd0);
        check_val({tag, "_pc_inc"},      o_fetch_pc_inc,        32'd4);
    endtask

    // One clock: drive inputs at the falling edge, check, then apply the edge
    // to the model. Called at a falling edge, returns at the next one.
    task automatic cycle();
        logic        exp_rv;
        logic        redir;
        logic        rsp;
        logic        pop;
        logic [31:0] tgt;
        logic [31:0] pc;
        int          lat;

        redir = force_redir || ($urandom_range(99) < redir_pct);
        tgt   = force_redir ? force_pc : $urandom;
        if (!force_redir && $urandom_range(3) == 0) begin
            tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        end
        force_redir      = 1'b0;
        i_redirect       = redir;
        i_redirect_pc    = tgt;
        i_imem_req_ready = ($urandom_range(99) < ready_pct);
        i_decode_ready   = ($urandom_range(99) < dready_pct);
        rsp              = (mem_q.size() > 0) && (mem_q[0].due <= edge_no);
        i_imem_rsp_valid = rsp;
        i_imem_rsp_data  = rsp ? (mem_q[0].addr ^ 32'h0000_00A5) : $urandom;
        #1;

        exp_rv = !redir && ((fifo_q.size() + kept_q.size() + discard_cnt) < DEPTH);
        check_val("req_valid", 32'(o_imem_req_valid), 32'(exp_rv));
        if (exp_rv) begin
            check_val("req_addr", o_imem_req_addr, model_pc);
        end
        if (fifo_q.size() > 0) begin
            check_val("fetch_valid", 32'(o_fetch_valid), 32'd1);
            check_val("fetch_inst",  o_fetch_inst,   fifo_q[0] ^ 32'h0000_00A5);
            check_val("fetch_pc",    o_fetch_pc,     fifo_q[0]);
            check_val("fetch_pc_inc", o_fetch_pc_inc, fifo_q[0] + 32'd4);
        end else begin
            check_val("empty_valid",  32'(o_fetch_valid), 32'd0);
            check_val("empty_inst",   o_fetch_inst,   NOP);
            check_val("empty_pc",     o_fetch_pc,     32'd0);
            check_val("empty_pc_inc", o_fetch_pc_inc, 32'd4);
        end

        @(posedge clk);
        if (rsp) begin
            void'(mem_q.pop_front());
        end
        if (redir) begin
            discard_cnt = discard_cnt + kept_q.size() - (rsp ? 1 : 0);
            kept_q.delete();
            fifo_q.delete();
            model_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            pop = (fifo_q.size() > 0) && i_decode_ready;
            if (pop) begin
                void'(fifo_q.pop_front());
            end
            if (rsp) begin
                if (discard_cnt > 0) begin
                    discard_cnt--;
                end else if (kept_q.size() > 0) begin
                    pc = kept_q.pop_front();
                    fifo_q.push_back(pc);
                end
            end
            if (exp_rv && i_imem_req_ready) begin
                lat = lat_min + $urandom_range(lat_max - lat_min);
                mem_q.push_back('{addr: model_pc, due: edge_no + lat});
                kept_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        edge_no++;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int rdy, input int drdy, input int rdr, input int lmin, input int lmax);
        ready_pct  = rdy;
        dready_pct = drdy;
        redir_pct  = rdr;
        lat_min    = lmin;
        lat_max    = lmax;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            cycle();
        end
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        edge_no          = 0;
        force_redir      = 1'b0;
        force_pc         = 32'd0;
        reset            = 1'b0;
        i_redirect       = 1'b0;
        i_redirect_pc    = 32'd0;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'd0;
        i_decode_ready   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b1;

        // Streaming with 1-cycle memory and decode always ready.
        set_knobs(100, 100, 0, 1, 1);
        run(20);

        // Decode stalled: fill to DEPTH, then drain and resume.
        set_knobs(100, 0, 0, 1, 1);
        run(10);
        set_knobs(100, 100, 0, 1, 1);
        run(10);

        // Redirect to an unaligned target with requests outstanding and a
        // response plus decode handshake landing on the redirect edge.
        set_knobs(100, 0, 0, 2, 2);
        run(3);
        force_redir = 1'b1;
        force_pc    = 32'h0000_2002;
        set_knobs(100, 100, 0, 2, 2);
        run(12);

        // Fetch PC wrap-around.
        set_knobs(100, 100, 0, 1, 1);
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFF8;
        run(8);

        // Random traffic.
        set_knobs(70, 60, 4, 1, 3);
        run(1500);

        // Reset asserted mid-stream with three buffered entries.
        set_knobs(100, 0, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            if (fifo_q.size() == 3) break;
            cycle();
        end
        check_val("pre_reset_count", 32'(fifo_q.size()), 32'd3);
        reset            = 1'b0;
        i_redirect       = 1'b0;
        i_imem_rsp_valid = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        model_reset();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        reset = 1'b1;
        set_knobs(100, 100, 0, 1, 1);
        run(10);

        // More random traffic.
        set_knobs(80, 50, 3, 1, 4);
        run(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
